// File: rtl/au_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer driving an 8-bit ripple add/sub unit.
// Owns every A/B/Cxor drive of the unit; one command in flight at a time.
module au_ripple #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cxor,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovr
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;

  assign bx   = b ^ {WIDTH{cxor}};
  assign c[0] = cxor;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[WIDTH];
  assign ovr  = c[WIDTH-1] ^ c[WIDTH];

endmodule

module au_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result,
  output logic               Cout,
  output logic               OVR,
  output logic               Zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             settle;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic             dp_cx;
  logic [WIDTH-1:0] dp_s;
  logic             dp_c;
  logic             dp_v;

  logic             accept;
  logic             last;
  logic             single;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] ms;
  logic             mc;
  logic             dacc;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  au_ripple #(
    .WIDTH(WIDTH)
  ) u_dp (
    .a   (dp_a),
    .b   (dp_b),
    .cxor(dp_cx),
    .s   (dp_s),
    .cout(dp_c),
    .ovr (dp_v)
  );

  assign accept = Start & ((state == IDLE) | (state == DONE));
  assign last   = (cnt == CW'(WIDTH - 1));
  // ADD/SUB and divide-by-zero finish straight out of EXEC
  assign single = ~op_q[1] | (op_q[0] & (b_q == '0));
  assign trial  = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign Zero   = (Result == '0);

  // hi/lo hold P_hi/P_lo for MUL and R/Q for DIV
  always_comb begin
    ms   = lo[0] ? dp_s : hi;
    mc   = lo[0] & dp_c;
    dacc = dp_c | hi[WIDTH-1];
    hi_n = hi;
    lo_n = lo;
    unique case (1'b1)
      ~op_q[0]: begin
        hi_n = {mc, ms[WIDTH-1:1]};
        lo_n = {ms[0], lo[WIDTH-1:1]};
      end
      op_q[0]: begin
        hi_n = dacc ? dp_s : trial;
        lo_n = {lo[WIDTH-2:0], dacc};
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (Start) state_n = EXEC;
      end
      EXEC: begin
        if (settle) state_n = single ? DONE : ITER;
      end
      ITER: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        state_n = Start ? EXEC : IDLE;
      end
    endcase
  end

  always_comb begin
    Busy  = 1'b0;
    Done  = 1'b0;
    dp_a  = '0;
    dp_b  = '0;
    dp_cx = 1'b0;
    unique case (state)
      IDLE: ;
      EXEC: begin
        Busy  = 1'b1;
        dp_a  = a_q;
        dp_b  = b_q;
        dp_cx = op_q[0];
      end
      ITER: begin
        Busy  = 1'b1;
        dp_a  = op_q[0] ? trial : hi;
        dp_b  = op_q[0] ? b_q : a_q;
        dp_cx = op_q[0];
      end
      DONE: begin
        Done = 1'b1;
      end
    endcase
  end

  // EXEC spends its first cycle letting latched operands settle the carry chain
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      settle <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      Result <= '0;
      Cout   <= 1'b0;
      OVR    <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= Op;
        a_q    <= OpA;
        b_q    <= OpB;
        settle <= 1'b0;
      end
      if (state == EXEC) begin
        settle <= 1'b1;
        if (settle) begin
          cnt <= '0;
          hi  <= '0;
          unique case (1'b1)
            ~op_q[1]: begin
              Result <= {{WIDTH{1'b0}}, dp_s};
              Cout   <= dp_c;
              OVR    <= dp_v;
            end
            op_q[1] & ~op_q[0]: begin
              lo <= b_q;
            end
            op_q[1] & op_q[0] & (b_q == '0): begin
              Result <= {a_q, {WIDTH{1'b1}}};
              Cout   <= 1'b0;
              OVR    <= 1'b1;
            end
            op_q[1] & op_q[0] & (b_q != '0): begin
              lo <= a_q;
            end
          endcase
        end
      end
      if (state == ITER) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          Result <= {hi_n, lo_n};
          Cout   <= 1'b0;
          OVR    <= ~op_q[0] & (hi_n != '0);
        end
      end
    end
  end

endmodule

// File: doc/au_sequencer.md
Name: au_sequencer

Overview:
Multi-cycle operation sequencer wrapped around an 8-bit ripple add/subtract datapath. The datapath has inputs A, B and Cxor, and outputs S, Cout and OVR. Cxor=1 inverts B and injects carry-in, so S=A-B. OVR is C7^C8.
The block accepts one command at a time through a Start/Busy/Done handshake. It executes ADD and SUB in a single pass. It executes unsigned MUL (shift-add) and unsigned DIV (restoring) as 8 datapath iterations each.
It sits between the lab control logic and the 8-bit arithmetic unit, and it owns every Cxor/A/B drive of that unit.

Parameters:
WIDTH, 8, operand width; the iteration count equals WIDTH; only 8 is verified.

Ports:
Clk  input  1  rising-edge clock
ResetN  input  1  synchronous active-low reset
Start  input  1  command request; accepted only when Busy=0
Op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
OpA  input  8  operand A / multiplicand / dividend
OpB  input  8  operand B / multiplier / divisor
Busy  output  1  high from the cycle after acceptance through the last iteration
Done  output  1  one-cycle pulse when Result and flags become valid
Result  output  16  ADD/SUB: {8'h00,S}; MUL: product; DIV: {remainder,quotient}
Cout  output  1  ADD/SUB: datapath Cout; MUL/DIV: 0
OVR  output  1  ADD/SUB: datapath OVR; MUL: Result[15:8]!=0; DIV: divide-by-zero
Zero  output  1  Result==16'h0000

Behaviour:
- Reset (ResetN=0 at a rising edge), from any state:
  - State goes to IDLE.
  - Busy, Done, Cout, OVR and Result all clear to 0.
  - Zero is 1.
  - Reset mid-operation abandons the operation and produces no Done.
- States: IDLE, EXEC, ITER, DONE.
- Start handling:
  - In IDLE or DONE, Start=1 at an edge latches Op, OpA and OpB, then moves to EXEC.
  - Start while Busy=1 is ignored; latched operands are unaffected.
- EXEC, ADD/SUB:
  - Drive A=OpA, B=OpB, Cxor=Op[0].
  - Register S, Cout and OVR into Result and the flags, then go to DONE.
- EXEC, MUL:
  - P_hi=0, P_lo=OpB, count=0; go to ITER.
- EXEC, DIV with OpB!=0:
  - R=0, Q=OpA, count=0; go to ITER.
- EXEC, DIV with OpB==0:
  - Result={OpA,8'hFF}, OVR=1; go to DONE with no iterations.
- ITER, MUL (per cycle):
  - If P_lo[0]=1, {c,s}=P_hi+OpA (Cxor=0); else {c,s}={0,P_hi}.
  - {P_hi,P_lo}={c,s,P_lo[7:1]}.
  - count+1.
- ITER, DIV (per cycle):
  - T={R[6:0],Q[7]}; trial T-OpB uses Cxor=1.
  - Accept when Cout=1 or R[7]=1. On accept, R=S and the shifted-in Q bit is 1. Otherwise R=T and the Q bit is 0.
  - Q shifts left.
  - count+1.
- ITER exit: after the 8th iteration (count==7 at the edge), load Result and flags, then go to DONE.
- DONE:
  - Done=1 for exactly one cycle, Busy=0.
  - Next state is IDLE, or EXEC if Start=1 (back-to-back, no bubble).
- Latency, with Start accepted at edge t:
  - ADD/SUB and DIV-by-zero: Done high in the cycle after edge t+2.
  - MUL/DIV: Done high in the cycle after edge t+10.
- Busy goes high after edge t and falls when Done rises.
- Result and flags hold their last values in IDLE; they update only on the transition into DONE. Zero is derived from the registered Result.
- Op and operand inputs are don't-care except at the accepting edge.
- Arithmetic wrap-around:
  - ADD/SUB are modulo 256; Cout and OVR report the carry and the signed overflow.
  - SUB Cout=1 means no borrow.

Test Plan:
- ADD: OpA=8'h7F, OpB=8'h01 -> Result=16'h0080, Cout=0, OVR=1, Zero=0, Done at t+2. Then OpA=FF, OpB=01 -> Result=0000, Cout=1, OVR=0, Zero=1.
- SUB: OpA=05, OpB=05 -> Result=0000, Cout=1, OVR=0, Zero=1. Then OpA=80, OpB=01 -> Result=007F, OVR=1, Cout=1.
- MUL: OpA=FF, OpB=FF -> Busy for 10 cycles, Result=16'hFE01, OVR=1, Done at t+10. Then OpA=0C, OpB=0B -> Result=0084, OVR=0.
- DIV: OpA=C8 (200), OpB=07 -> Result=16'h041C (r=4, q=28), OVR=0. Then OpA=0x64, OpB=00 -> Result=64FF, OVR=1, Done at t+2.
- Handshake: Start held high continuously with alternating ADD/MUL -> a second Start during Busy is ignored. The Start sampled in the DONE cycle is accepted with no IDLE gap, and each Done is exactly one cycle.
- Reset: ResetN=0 for one edge during the 4th MUL iteration -> Busy=0, Result=0000, Zero=1, no Done. A new ADD 01+02 afterwards -> Result=0003.
